// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared types and constants for the 1-to-8 byte demultiplexer
//
// Purpose: common widths and typedefs used by demux_reg and demux_slot.
// Contents:
//   WIDTH_DEF - default channel data width
//   N_CH      - number of output channels
//   chan_t    - channel index type
//   data_t    - byte type at the default width
package demux_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int N_CH      = 8;

  typedef logic [2:0]           chan_t;
  typedef logic [WIDTH_DEF-1:0] data_t;

endpackage

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one-entry channel holding register with valid flag
//
// Purpose: holds one byte for a single consumer until it is taken.
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset
//   load     - write data_in this cycle (wins over drain)
//   data_in  - byte to store
//   drain    - consumer takes the held byte this cycle
//   data_out - held byte (meaningful only while valid=1)
//   valid    - slot holds an unconsumed byte
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             drain,
  output logic [WIDTH-1:0] data_out,
  output logic             valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= '0;
      valid    <= 1'b0;
    end else if (load) begin
      // A load in the same cycle as a drain replaces the byte and keeps valid high,
      // which is what lets one channel sustain a byte per cycle.
      data_out <= data_in;
      valid    <= 1'b1;
    end else if (drain) begin
      // Data is left as-is; only the flag is cleared.
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_reg.sv
// rtl/demux_reg.sv - registered 1-to-8 byte demultiplexer with round-robin option
//
// Purpose: accepts one byte per cycle and steers it into one of eight channel
// holding registers, chosen by select or by an internal round-robin pointer.
// Ports:
//   clk, rst   - clock (rising edge) and asynchronous active-high reset
//   entrada    - input byte
//   select     - destination channel when modo_auto=0
//   modo_auto  - 1: destination is ptr, 0: destination is select
//   in_valid   - producer offers entrada
//   in_ready   - demux can accept this cycle
//   c0..c7     - channel holding-register contents
//   out_valid  - bit k: channel k holds an unconsumed byte
//   out_ready  - bit k: consumer k takes its byte this cycle
//   ptr        - round-robin pointer
//   aceitos    - saturating count of accepted bytes
module demux_reg
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] entrada,
  input  logic [2:0]       select,
  input  logic             modo_auto,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] c0,
  output logic [WIDTH-1:0] c1,
  output logic [WIDTH-1:0] c2,
  output logic [WIDTH-1:0] c3,
  output logic [WIDTH-1:0] c4,
  output logic [WIDTH-1:0] c5,
  output logic [WIDTH-1:0] c6,
  output logic [WIDTH-1:0] c7,
  output logic [N_CH-1:0]  out_valid,
  input  logic [N_CH-1:0]  out_ready,
  output logic [2:0]       ptr,
  output logic [CNT_W-1:0] aceitos
);

  chan_t           dest;
  logic            accept;
  logic [N_CH-1:0] load;
  logic [N_CH-1:0] drain;
  logic [WIDTH-1:0] data_q [N_CH];

  // Destination and readiness are purely combinational; in_ready must not look
  // at in_valid so the producer can use it to decide whether to offer.
  always_comb begin
    dest     = modo_auto ? chan_t'(ptr) : chan_t'(select);
    in_ready = !out_valid[dest] || out_ready[dest];
    accept   = in_valid && in_ready;
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_slot
    assign load[k]  = accept && (dest == 3'(k));
    assign drain[k] = out_valid[k] && out_ready[k];

    demux_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .load     (load[k]),
      .data_in  (entrada),
      .drain    (drain[k]),
      .data_out (data_q[k]),
      .valid    (out_valid[k])
    );
  end

  assign c0 = data_q[0];
  assign c1 = data_q[1];
  assign c2 = data_q[2];
  assign c3 = data_q[3];
  assign c4 = data_q[4];
  assign c5 = data_q[5];
  assign c6 = data_q[6];
  assign c7 = data_q[7];

  // Pointer advances only on accepts made in auto mode; switching modes leaves it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept && modo_auto) begin
      ptr <= ptr + 3'd1;
    end
  end

  // Saturating accepted-byte counter: holds at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aceitos <= '0;
    end else if (accept && (aceitos != {CNT_W{1'b1}})) begin
      aceitos <= aceitos + 1'b1;
    end
  end

endmodule

// File: tb/tb_demux_reg.sv
// tb/tb_demux_reg.sv - table-driven self-checking bench for demux_reg
module tb_demux_reg;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    entrada = '0;
  logic [2:0]    select = '0;
  logic          modo_auto = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    c0, c1, c2, c3, c4, c5, c6, c7;
  logic [7:0]    out_valid;
  logic [7:0]    out_ready = '0;
  logic [2:0]    ptr;
  logic [CW-1:0] aceitos;

  int checks = 0;
  int errors = 0;

  demux_reg #(.WIDTH(8), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .entrada(entrada), .select(select), .modo_auto(modo_auto),
    .in_valid(in_valid), .in_ready(in_ready),
    .c0(c0), .c1(c1), .c2(c2), .c3(c3), .c4(c4), .c5(c5), .c6(c6), .c7(c7),
    .out_valid(out_valid), .out_ready(out_ready), .ptr(ptr), .aceitos(aceitos)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rst_b;
    logic       iv;
    logic       ma;
    logic [2:0] sel;
    logic [7:0] d;
    logic [7:0] ordy;
    logic       e_ir;
    logic [7:0] e_ov;
    logic [2:0] e_ptr;
    logic [3:0] e_acc;
    logic [2:0] e_ch;
    logic [7:0] e_dat;
  } vec_t;

  vec_t vq[$];

  function automatic logic [7:0] chan(input logic [2:0] k);
    case (k)
      3'd0: chan = c0;
      3'd1: chan = c1;
      3'd2: chan = c2;
      3'd3: chan = c3;
      3'd4: chan = c4;
      3'd5: chan = c5;
      3'd6: chan = c6;
      default: chan = c7;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input bit rb, input logic iv, input logic ma, input logic [2:0] sel,
                              input logic [7:0] d, input logic [7:0] ordy, input logic e_ir,
                              input logic [7:0] e_ov, input logic [2:0] e_ptr,
                              input logic [3:0] e_acc, input logic [2:0] e_ch,
                              input logic [7:0] e_dat);
    vec_t v;
    v.rst_b = rb; v.iv = iv; v.ma = ma; v.sel = sel; v.d = d; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_ptr = e_ptr; v.e_acc = e_acc; v.e_ch = e_ch; v.e_dat = e_dat;
    vq.push_back(v);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0; out_ready = '0; modo_auto = 1'b0; select = '0; entrada = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic apply(input vec_t v, input int idx);
    if (v.rst_b) do_reset();
    @(negedge clk);
    in_valid = v.iv; modo_auto = v.ma; select = v.sel; entrada = v.d; out_ready = v.ordy;
    #1;
    check($sformatf("in_ready[%0d]", idx), 32'(in_ready), 32'(v.e_ir));
    @(posedge clk);
    #1;
    check($sformatf("out_valid[%0d]", idx), 32'(out_valid), 32'(v.e_ov));
    check($sformatf("ptr[%0d]", idx), 32'(ptr), 32'(v.e_ptr));
    check($sformatf("aceitos[%0d]", idx), 32'(aceitos), 32'(v.e_acc));
    check($sformatf("c%0d[%0d]", v.e_ch, idx), 32'(chan(v.e_ch)), 32'(v.e_dat));
  endtask

  initial begin
    // Explicit select, all consumers ready: each byte lives one cycle.
    add(1, 1, 0, 3'd0, 8'h11, 8'hFF, 1, 8'h01, 3'd0, 4'd1, 3'd0, 8'h11);
    add(0, 1, 0, 3'd1, 8'h22, 8'hFF, 1, 8'h02, 3'd0, 4'd2, 3'd1, 8'h22);
    add(0, 1, 0, 3'd2, 8'h33, 8'hFF, 1, 8'h04, 3'd0, 4'd3, 3'd2, 8'h33);
    add(0, 1, 0, 3'd3, 8'h44, 8'hFF, 1, 8'h08, 3'd0, 4'd4, 3'd3, 8'h44);
    add(0, 1, 0, 3'd4, 8'h55, 8'hFF, 1, 8'h10, 3'd0, 4'd5, 3'd4, 8'h55);
    add(0, 1, 0, 3'd5, 8'h66, 8'hFF, 1, 8'h20, 3'd0, 4'd6, 3'd5, 8'h66);
    add(0, 1, 0, 3'd6, 8'h77, 8'hFF, 1, 8'h40, 3'd0, 4'd7, 3'd6, 8'h77);
    add(0, 1, 0, 3'd7, 8'h88, 8'hFF, 1, 8'h80, 3'd0, 4'd8, 3'd7, 8'h88);
    add(0, 0, 0, 3'd2, 8'hEE, 8'hFF, 1, 8'h00, 3'd0, 4'd8, 3'd7, 8'h88);
    // Backpressure on channel 3, then simultaneous drain and refill.
    add(1, 1, 0, 3'd3, 8'hA5, 8'h00, 1, 8'h08, 3'd0, 4'd1, 3'd3, 8'hA5);
    add(0, 1, 0, 3'd3, 8'h5A, 8'h00, 0, 8'h08, 3'd0, 4'd1, 3'd3, 8'hA5);
    add(0, 1, 0, 3'd3, 8'h5A, 8'h08, 1, 8'h08, 3'd0, 4'd2, 3'd3, 8'h5A);
    add(0, 0, 0, 3'd3, 8'h00, 8'h08, 1, 8'h00, 3'd0, 4'd2, 3'd3, 8'h5A);
    // Auto mode: ten bytes wrap the pointer to 2.
    for (int i = 0; i < 10; i++)
      add(i == 0, 1, 1, 3'd5, 8'(8'hC0 + i), 8'hFF, 1, 8'(1 << (i % 8)),
          3'((i + 1) % 8), 4'(i + 1), 3'(i % 8), 8'(8'hC0 + i));
    // Mode switch: pointer survives a detour through explicit select.
    add(1, 1, 1, 3'd0, 8'hB0, 8'hFF, 1, 8'h01, 3'd1, 4'd1, 3'd0, 8'hB0);
    add(0, 1, 1, 3'd0, 8'hB1, 8'hFF, 1, 8'h02, 3'd2, 4'd2, 3'd1, 8'hB1);
    add(0, 1, 1, 3'd0, 8'hB2, 8'hFF, 1, 8'h04, 3'd3, 4'd3, 3'd2, 8'hB2);
    add(0, 1, 0, 3'd6, 8'h6E, 8'hFF, 1, 8'h40, 3'd3, 4'd4, 3'd6, 8'h6E);
    add(0, 1, 1, 3'd6, 8'h3C, 8'hFF, 1, 8'h08, 3'd4, 4'd5, 3'd3, 8'h3C);
    // Saturation of the 4-bit counter.
    for (int i = 0; i < 20; i++)
      add(i == 0, 1, 0, 3'd0, 8'(i), 8'hFF, 1, 8'h01, 3'd0, 4'((i + 1 > 15) ? 15 : i + 1),
          3'd0, 8'(i));

    // Power-on reset state.
    rst = 1'b1;
    #12;
    check("reset_out_valid", 32'(out_valid), 32'h0);
    check("reset_ptr", 32'(ptr), 32'h0);
    check("reset_aceitos", 32'(aceitos), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

    // Reset mid-traffic: fill every channel with consumers stalled, ptr left at 5.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1; out_ready = '0; entrada = 8'(8'hD0 + i);
      modo_auto = (i < 5); select = 3'(i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("fill_out_valid", 32'(out_valid), 32'hFF);
    check("fill_ptr", 32'(ptr), 32'd5);
    check("fill_c7", 32'(c7), 32'hD7);
    check("fill_in_ready", 32'(in_ready), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("async_out_valid", 32'(out_valid), 32'h0);
    check("async_ptr", 32'(ptr), 32'h0);
    check("async_aceitos", 32'(aceitos), 32'h0);
    for (int k = 0; k < 8; k++) check($sformatf("async_c%0d", k), 32'(chan(3'(k))), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_reg.md
Name: demux_reg

Overview:
Registered 1-to-8 byte demultiplexer: the distribution end of the 8-channel selector path. It accepts one byte per cycle on a valid/ready input. Each byte goes to one of eight channel holding registers (c0..c7), chosen either by an explicit select or by an internal round-robin pointer. Each channel presents its byte to its own consumer with a per-channel valid/ready handshake.

Parameters:
WIDTH, 8, data width of input and of each channel
CNT_W, 16, width of the accepted-byte counter

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
entrada  input  WIDTH  input byte
select  input  3  destination channel when modo_auto=0
modo_auto  input  1  1 = destination is internal pointer ptr; 0 = destination is select
in_valid  input  1  producer offers entrada
in_ready  output  1  demux can accept this cycle
c0..c7  output  WIDTH each  channel holding-register contents
out_valid  output  8  bit k = channel k holds unconsumed byte
out_ready  input  8  bit k = consumer k takes byte this cycle
ptr  output  3  current round-robin pointer
aceitos  output  CNT_W  count of accepted input bytes, saturating

Behaviour:
- Reset (async assert, sync-safe deassert): c0..c7 = 0, out_valid = 0, ptr = 0, aceitos = 0. Any byte held at reset is discarded.
- dest = modo_auto ? ptr : select. This is combinational and evaluated every cycle.
- in_ready = !out_valid[dest] || out_ready[dest]. This is combinational, with no dependency on in_valid.
- Accept = in_valid && in_ready.
- On accept at edge N:
  - c[dest] <= entrada.
  - out_valid[dest] <= 1.
  - The byte is visible from cycle N+1 (latency 1).
- Drain of channel k (out_valid[k] && out_ready[k]):
  - If no accept to k in the same cycle, out_valid[k] <= 0 and c[k] holds its old value.
  - Simultaneous drain of k and accept to k: the new byte replaces the old, out_valid[k] stays 1. This allows 1 byte/cycle sustained on one channel.
- Channels drain independently. Any number of out_ready bits may be set in one cycle.
- ptr:
  - Increments by 1 mod 8 on every accept while modo_auto=1 (7 -> 0 wrap).
  - Unchanged on accepts with modo_auto=0.
  - Toggling modo_auto never resets ptr.
- aceitos:
  - Increments on every accept in either mode.
  - Saturates at 2^CNT_W-1; it never wraps.
- in_valid=0 and changes to entrada or select never alter state.
- A stalled input (channel full, consumer not ready) leaves ptr, aceitos and all registers unchanged.
- Output values are defined only while out_valid[k]=1. Consumers must not sample otherwise.

Decomposition:
- Package demux_pkg holds:
  - WIDTH_DEF=8, N_CH=8.
  - typedef chan_t (logic [2:0]).
  - typedef data_t (logic [WIDTH-1:0]).
- Sub-module demux_slot: one-entry holding register with a valid flag.
  - Ports: clk, rst, load, data_in, drain; outputs data_out, valid.
  - Instantiated 8 times; the top contains dest/ready logic, ptr and the counter.

Test Plan:
- Reset mid-traffic: assert rst with out_valid=8'hFF -> next sample out_valid=0, c0..c7=0, ptr=0, aceitos=0, with no clock edge required.
- Explicit select, out_ready=8'hFF: send 0x11..0x88 with select=0..7 -> each out_valid bit pulses one cycle after its accept with c[k] = 0x11*(k+1), and aceitos=8.
- Backpressure: out_ready=0, select=3, send 0xA5 then 0x5A:
  - in_ready drops after the first byte; c3 stays 0xA5.
  - Raising out_ready[3] drains it and accepts 0x5A in the same cycle, with out_valid[3] staying 1.
- Auto mode wrap: modo_auto=1, all ready, send 10 bytes -> channels 0..7 then 0,1 are written, ptr ends at 2, aceitos=10.
- Mode switch: modo_auto=1, accept 3 bytes (ptr=3); switch to 0 with select=6 and accept 1 -> byte goes to c6, ptr stays 3; return to auto -> next byte goes to c3.
- Saturation (CNT_W=4): accept 20 bytes -> aceitos holds at 15.
